regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register value width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (32 registers, x0 hardwired zero).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  write request valid (req0 = execute writeback, req1 = load writeback).
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_addr / req1_addr  input  ADDR_WIDTH  destination register.
REQ-008 SHALL have ports req0_data / req1_data  input  DATA_WIDTH  value to write.
REQ-009 SHALL have port claim_valid  input  1  mark a destination register pending (issue stage).
REQ-010 SHALL have port claim_addr  input  ADDR_WIDTH  register being claimed.
REQ-011 SHALL have port rf_write_enable  output  1  drives register-file write enable.
REQ-012 SHALL have port rf_address_write  output  ADDR_WIDTH  drives register-file write address.
REQ-013 SHALL have port rf_value_write  output  DATA_WIDTH  drives register-file write value.
REQ-014 SHALL have port busy  output  2**ADDR_WIDTH  per-register pending bit (scoreboard).

Function
REQ-015 SHALL transfer a request when reqN_valid && reqN_ready on a rising edge; requester holds addr/data stable while valid && !ready.
REQ-016 SHALL assert at most one of req0_ready / req1_ready per cycle; ready is combinational from valid and arbitration state; a requester with valid low gets ready low.
REQ-017 SHALL grant the sole valid requester immediately; on contention SHALL grant per the policy of REQ-027.
REQ-018 SHALL register the granted request: accepted in cycle N -> rf_write_enable=1, rf_address_write, rf_value_write presented throughout cycle N+1 (latency 1); no accept in N -> rf_write_enable=0 in N+1.
REQ-019 SHALL sustain one accepted write per cycle (back-to-back grants, no bubble).
REQ-020 SHALL accept requests addressed to x0 but drive rf_write_enable=0 for them; rf_address_write/rf_value_write still update.
REQ-021 SHALL set busy[claim_addr] on the edge where claim_valid=1 and claim_addr!=0; busy[0] is constant 0.
REQ-022 SHALL clear busy[a] on the edge ending the cycle in which rf_write_enable=1 with rf_address_write=a.
REQ-023 SHALL, on simultaneous set and clear of the same address, leave busy set (claim wins).
REQ-024 SHALL leave busy unchanged for writes to registers not marked busy; no error flagged.

Reset
REQ-025 SHALL, on reset_n low (asynchronously, any cycle including mid-transfer), force rf_write_enable=0, rf_address_write=0, rf_value_write=0, busy=0, round-robin pointer to requester 0; an in-flight registered write is dropped.
REQ-026 SHALL drive req0_ready=req1_ready=0 while reset_n is low.

Configuration
REQ-027 SHALL support macro REGFILE_ARB_ROUND_ROBIN_EN: defined -> round-robin, pointer moves to the non-granted requester after each contended grant (uncontended grant also moves pointer to the other requester); undefined -> fixed priority, req1 (load) always wins, no pointer state.

Structure
REQ-028 SHALL take ADDR_WIDTH/DATA_WIDTH defaults and a write-request struct type (valid, addr, data) from shared package regfile_pkg.
REQ-029 SHALL place the two-input grant logic (including pointer under REGFILE_ARB_ROUND_ROBIN_EN) in sub-module regfile_arb_pick; output register and scoreboard stay in the top module.

Verification
REQ-030 SHALL cover: req0 only, addr=5 data=0x1234_5678 -> req0_ready=1 same cycle, next cycle rf_write_enable=1 addr=5 value=0x1234_5678.
REQ-031 SHALL cover: both valid 4 cycles, addrs 3/7 -> round-robin: grants 0,1,0,1 (pointer reset to 0); fixed priority: req1 granted 4 times, req0_ready=0 throughout.
REQ-032 SHALL cover: req1 to addr 0, data 0xFFFF_FFFF -> req1_ready=1, next cycle rf_write_enable=0.
REQ-033 SHALL cover: claim addr 9, then write addr 9 -> busy[9]=1 after claim edge, 0 one edge after rf write cycle; claim 9 in same cycle as rf write to 9 -> busy[9] stays 1.
REQ-034 SHALL cover: claim addr 0 -> busy stays all-zero.
REQ-035 SHALL cover: reset_n pulsed low mid-cycle while rf_write_enable=1 and busy[4]=1 -> all outputs 0 immediately without a clock edge, ready low during reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
// The request struct is sized by the package default widths; instances of the
// arbiter are expected to use those same widths.
package regfile_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    typedef struct packed {
        logic                      valid;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_arb_pick.sv
// Two-input grant selection for the write arbiter.
// Macro REGFILE_ARB_ROUND_ROBIN_EN: defined -> round-robin with a one-bit
// pointer; undefined -> fixed priority, input 1 (load) always wins.
module regfile_arb_pick (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    // r_ptr names the requester that wins the next contended cycle
    logic r_ptr;

    // Grant the sole requester, or the pointed-to one on contention
    always_comb begin
        o_grant0 = i_valid0 & (~i_valid1 | ~r_ptr);
        o_grant1 = i_valid1 & (~i_valid0 |  r_ptr);
    end

    // After any grant the pointer moves to the requester that was not served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (o_grant0 | o_grant1) begin
            r_ptr <= o_grant0;
        end
    end
`else
    // Fixed priority: load writeback always wins
    always_comb begin
        o_grant1 = i_valid1;
        o_grant0 = i_valid0 & ~i_valid1;
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: picks one of two writeback requesters per
// cycle, registers the winning write toward the register file, and keeps a
// per-register pending (busy) scoreboard set by issue claims and cleared by
// completed writes. x0 writes are accepted but never enabled.
// Macro REGFILE_ARB_ROUND_ROBIN_EN selects round-robin instead of
// load-first fixed priority (see regfile_arb_pick).
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [ADDR_WIDTH-1:0]      req0_addr,
    input  logic [DATA_WIDTH-1:0]      req0_data,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [ADDR_WIDTH-1:0]      req1_addr,
    input  logic [DATA_WIDTH-1:0]      req1_data,
    input  logic                       claim_valid,
    input  logic [ADDR_WIDTH-1:0]      claim_addr,
    output logic                       rf_write_enable,
    output logic [ADDR_WIDTH-1:0]      rf_address_write,
    output logic [DATA_WIDTH-1:0]      rf_value_write,
    output logic [(2**ADDR_WIDTH)-1:0] busy
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic            w_grant0;
    logic            w_grant1;
    wr_req_t         w_sel;
    wr_req_t         r_wr;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    regfile_arb_pick u_pick (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst_n    (reset_n),
`endif
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    // Ready is held low while reset is asserted so nothing transfers then
    assign req0_ready = w_grant0 & reset_n;
    assign req1_ready = w_grant1 & reset_n;

    // Mux the accepted request; valid marks that a transfer happens this cycle
    always_comb begin
        w_sel.valid = req0_ready | req1_ready;
        w_sel.addr  = req1_ready ? req1_addr : req0_addr;
        w_sel.data  = req1_ready ? req1_data : req0_data;
    end

    // Output register: one cycle latency; x0 updates addr/data but never enables
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= '0;
        end else begin
            r_wr.valid <= w_sel.valid && (w_sel.addr != '0);
            if (w_sel.valid) begin
                r_wr.addr <= w_sel.addr;
                r_wr.data <= w_sel.data;
            end
        end
    end

    assign rf_write_enable  = r_wr.valid;
    assign rf_address_write = r_wr.addr;
    assign rf_value_write   = r_wr.data;

    // Scoreboard next state: completed write clears, claim applied last so it wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr.valid) begin
            w_busy_nxt[r_wr.addr] = 1'b0;
        end
        if (claim_valid) begin
            w_busy_nxt[claim_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Stimulus steps push the expected
// register-file write for each cycle into a queue; a monitor on the falling
// edge pops and compares it against the registered outputs.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr, claim_addr, rf_address_write;
    logic [31:0] req0_data, req1_data, rf_value_write;
    logic        claim_valid, rf_write_enable;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        acc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_addr        (req0_addr),
        .req0_data        (req0_data),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_addr        (req1_addr),
        .req1_data        (req1_data),
        .claim_valid      (claim_valid),
        .claim_addr       (claim_addr),
        .rf_write_enable  (rf_write_enable),
        .rf_address_write (rf_address_write),
        .rf_value_write   (rf_value_write),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; er0/er1 are the hand-computed ready values
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic cv, input logic [4:0] ca,
                        input logic er0, input logic er1, input string name);
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        claim_valid = cv; claim_addr = ca;
        #1;
        chk({name, " req0_ready"}, {63'd0, req0_ready}, {63'd0, er0});
        chk({name, " req1_ready"}, {63'd0, req1_ready}, {63'd0, er1});
        e.acc  = er0 | er1;
        e.addr = er1 ? a1 : a0;
        e.data = er1 ? d1 : d0;
        e.we   = e.acc && (e.addr != 5'd0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, name);
    endtask

    task automatic check_busy(input string name, input logic [31:0] exp);
        @(posedge clk);
        #2;
        chk(name, {32'd0, busy}, {32'd0, exp});
    endtask

    // Monitor: compare the registered write presented in each cycle
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_write_enable", {63'd0, rf_write_enable}, {63'd0, e.we});
            if (e.acc) begin
                chk("rf_address_write", {59'd0, rf_address_write}, {59'd0, e.addr});
                chk("rf_value_write", {32'd0, rf_value_write}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
        claim_valid = 1'b0; claim_addr = 5'd0;
        #3;
        chk("reset rf_write_enable", {63'd0, rf_write_enable}, 64'd0);
        chk("reset rf_address_write", {59'd0, rf_address_write}, 64'd0);
        chk("reset rf_value_write", {32'd0, rf_value_write}, 64'd0);
        chk("reset busy", {32'd0, busy}, 64'd0);
        chk("reset req0_ready", {63'd0, req0_ready}, 64'd0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        reset_n = 1'b1;

        // Single requester, normal and x0 destinations
        step(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0, "req0 only");
        step(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, "req1 to x0");

        // Contention, pointer back at requester 0 here
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        step(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007, 0, 0, 1, 0, "contend c0");
        step(1, 5'd3, 32'hAAAA_1003, 1, 5'd7, 32'hBBBB_0007, 0, 0, 0, 1, "contend c1");
        step(1, 5'd3, 32'hAAAA_1003, 1, 5'd7, 32'hBBBB_1007, 0, 0, 1, 0, "contend c2");
        step(1, 5'd3, 32'hAAAA_2003, 1, 5'd7, 32'hBBBB_1007, 0, 0, 0, 1, "contend c3");
`else
        step(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007, 0, 0, 0, 1, "contend c0");
        step(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_1007, 0, 0, 0, 1, "contend c1");
        step(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_2007, 0, 0, 0, 1, "contend c2");
        step(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_3007, 0, 0, 0, 1, "contend c3");
`endif
        idle("drain");

        // Claim of x0 is ignored
        step(0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, "claim x0");
        check_busy("busy after claim x0", 32'h0);

        // Claim then write clears one edge after the write cycle
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, "claim 9");
        check_busy("busy after claim 9", 32'h0000_0200);
        step(1, 5'd9, 32'h0000_0909, 0, 0, 0, 0, 0, 1, 0, "write 9");
        check_busy("busy during write 9", 32'h0000_0200);
        idle("write 9 done");
        check_busy("busy cleared 9", 32'h0);

        // Claim in the same cycle as the write to 9: claim wins
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, "reclaim 9");
        check_busy("busy reclaim 9", 32'h0000_0200);
        step(1, 5'd9, 32'h0000_1909, 0, 0, 0, 0, 0, 1, 0, "write 9 again");
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, "claim during write");
        check_busy("busy claim wins", 32'h0000_0200);

        // Write to a register that is not pending leaves busy alone
        step(0, 0, 0, 1, 5'd12, 32'h0000_000C, 0, 0, 0, 1, "write 12");
        idle("write 12 done");
        check_busy("busy unchanged by write 12", 32'h0000_0200);

        // Asynchronous reset in the middle of an active write
        step(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, "claim 4");
        step(1, 5'd6, 32'hCAFE_0006, 0, 0, 0, 0, 0, 1, 0, "write 6");
        @(posedge clk);
        #2;
        chk("pre-reset rf_write_enable", {63'd0, rf_write_enable}, 64'd1);
        chk("pre-reset busy", {32'd0, busy}, {32'd0, 32'h0000_0210});
        reset_n = 1'b0;
        #1;
        chk("async rf_write_enable", {63'd0, rf_write_enable}, 64'd0);
        chk("async rf_address_write", {59'd0, rf_address_write}, 64'd0);
        chk("async rf_value_write", {32'd0, rf_value_write}, 64'd0);
        chk("async busy", {32'd0, busy}, 64'd0);
        chk("async req0_ready", {63'd0, req0_ready}, 64'd0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        reset_n = 1'b1;

        // After reset the pointer favours requester 0 again
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        step(1, 5'd3, 32'h0000_3333, 1, 5'd7, 32'h0000_7777, 0, 0, 1, 0, "post-reset contend");
`else
        step(1, 5'd3, 32'h0000_3333, 1, 5'd7, 32'h0000_7777, 0, 0, 0, 1, "post-reset contend");
`endif
        idle("final drain");
        @(negedge clk);
        #1;
        chk("scoreboard empty", {32'd0, exp_q.size()}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
